// File: rtl/prog_encoder.sv
// prog_encoder
//    Turns a stream of decoded instruction field tuples back into 8-bit
//    instruction words and writes them sequentially into imem. The boot/test
//    loader uses it to place a program in imem before the core is released.
//    Field combinations the ISA cannot represent, or a program that does not
//    fit in imem, stop the load in an error state until the next start.
//
// Ports
//    clk_i          clock, all state updates on the rising edge
//    rst_i          synchronous reset, active-high
//    start_i        begin a load (honoured in IDLE, DONE and ERR only)
//    in_valid_i     field tuple present
//    in_ready_o     tuple accepted this cycle when in_valid_i is high
//    in_opcode_i    opcode field
//    in_rs1_i       source/dest register 1
//    in_rs2_i       source register 2
//    in_fn_i        function select bit
//    in_imm_i       immediate
//    in_last_i      tuple is the final instruction of the program
//    imem_we_o      imem write strobe
//    imem_addr_o    imem write address
//    imem_wdata_o   encoded instruction word
//    count_o        words written since start
//    done_o         one-cycle pulse alongside the final write
//    err_o          high while in ERR (sticky until the next start)
//    err_code_o     00 none, 01 illegal fields, 10 overflow
//    err_addr_o     address of the offending beat
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, waiting for start
// RUN    | accepting field tuples, one per cycle
// DONE   | final word written, waiting for a new start
// ERR    | illegal tuple or overflow seen, waiting for a new start

module prog_encoder #(
   parameter int                ADDR_W    = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        in_opcode_i,
   input  logic [1:0]        in_rs1_i,
   input  logic [1:0]        in_rs2_i,
   input  logic              in_fn_i,
   input  logic [3:0]        in_imm_i,
   input  logic              in_last_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [7:0]        imem_wdata_o,
   output logic [ADDR_W:0]   count_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_FINAL = (ADDR_W + 1)'(DEPTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic [7:0] enc_word;
   logic       enc_legal;
   logic       accept;

   // Field packing; the bit scatter mirrors the decoder's extraction.
   always_comb begin
      enc_word       = '0;
      enc_legal      = 1'b1;
      enc_word[2:0]  = in_opcode_i;
      case (in_opcode_i)
         3'b000, 3'b011, 3'b100: begin
            enc_word[3] = in_fn_i;
            enc_word[4] = in_rs1_i[1];
            enc_word[6] = in_rs1_i[0];
            enc_word[5] = in_rs2_i[1];
            enc_word[7] = in_rs2_i[0];
         end
         3'b001, 3'b101: begin
            enc_word[6]   = in_rs1_i[0];
            enc_word[7]   = in_rs2_i[0];
            enc_word[5:3] = in_imm_i[2:0];
            enc_legal     = ~(in_rs1_i[1] | in_rs2_i[1] | in_imm_i[3]);
         end
         3'b010: begin
            enc_word[7]   = in_rs1_i[0];
            enc_word[6:3] = in_imm_i;
            enc_legal     = ~in_rs1_i[1];
         end
         3'b111: begin
            enc_word[3]   = 1'b1;
            enc_word[7:4] = in_imm_i;
            enc_legal     = in_fn_i;
         end
         default: begin
            enc_legal = 1'b0;
         end
      endcase
   end

   assign accept = in_valid_i && (state_q == S_RUN);

   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      wr_addr_d   = wr_addr_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      done_d      = 1'b0;
      count_d     = count_q;
      err_code_d  = err_code_q;
      err_addr_d  = err_addr_q;
      case (state_q)
         S_RUN: begin
            if (accept) begin
               if (!enc_legal) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_ILLEGAL;
                  err_addr_d = next_addr_q;
               end else begin
                  we_d        = 1'b1;
                  wr_addr_d   = next_addr_q;
                  wdata_d     = enc_word;
                  next_addr_d = next_addr_q + 1'b1;
                  count_d     = count_q + 1'b1;
                  // The word that fills imem is still written; only a
                  // missing last flag on it turns the load into an overflow.
                  if (in_last_i) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (count_q == CNT_FINAL) begin
                     state_d    = S_ERR;
                     err_code_d = ERR_OVERFLOW;
                     err_addr_d = next_addr_q;
                  end
               end
            end
         end
         default: begin
            if (start_i) begin
               state_d     = S_RUN;
               next_addr_d = BASE_ADDR;
               count_d     = '0;
               err_code_d  = ERR_NONE;
               err_addr_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         next_addr_q <= BASE_ADDR;
         wr_addr_q   <= BASE_ADDR;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         count_q     <= '0;
         err_code_q  <= ERR_NONE;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         wr_addr_q   <= wr_addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         done_q      <= done_d;
         count_q     <= count_d;
         err_code_q  <= err_code_d;
         err_addr_q  <= err_addr_d;
      end
   end

   // A write already registered when rst rises must not reach imem, so the
   // strobes are masked in the reset cycle itself.
   assign imem_we_o    = we_q & ~rst_i;
   assign done_o       = done_q & ~rst_i;
   assign imem_addr_o  = wr_addr_q;
   assign imem_wdata_o = wdata_q;
   assign in_ready_o   = (state_q == S_RUN);
   assign count_o      = count_q;
   assign err_o        = (state_q == S_ERR);
   assign err_code_o   = err_code_q;
   assign err_addr_o   = err_addr_q;

endmodule
